reg_write_scoreboard: RTL
=========================

Name: reg_write_scoreboard

Overview:
- Write-side companion to the register-read decoder. It tracks in-flight destination-register writes through the EX, MEM and WB stages.
- It compares each ID-stage instruction's read requests (ReadRs/ReadRt plus rs/rt) against those pending writes.
- It produces the pipeline stall and registered forwarding selects.
- It sits between ID control decode and the ID/EX pipeline register.

Parameters:
- REG_AW, 5, register index width (32 GPRs; register 0 is never tracked).
- FWD_W, 2, forwarding select width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- hold  input  1  global freeze (memory wait); no state advances.
- flush  input  1  branch/exception flush of the ID instruction entering EX.
- id_valid  input  1  ID holds a real instruction.
- id_read_rs  input  1  ReadRs from register-read decoder.
- id_read_rt  input  1  ReadRt from register-read decoder.
- id_rs  input  REG_AW  rs field.
- id_rt  input  REG_AW  rt field.
- id_wr_en  input  1  ID instruction writes a GPR.
- id_wr_reg  input  REG_AW  destination register (rd/rt/31 already muxed).
- id_is_load  input  1  ID instruction is LW.
- stall  output  1  freeze PC/IF/ID and inject a bubble into EX (combinational).
- ex_fwd_rs  output  FWD_W  operand-A source for the instruction now in EX (registered).
- ex_fwd_rt  output  FWD_W  operand-B source for the instruction now in EX (registered).

Behaviour:
- State is three entries, EX/MEM/WB. Each entry holds valid, reg, and is_load. An entry is "live" when valid=1, wr_en=1 and reg!=0.
- Match definition: ID reads register r (read flag set, r!=0) and a live entry has reg==r.
- Forwarding encoding:
  - 00 = register file.
  - 01 = EX/MEM ALU result.
  - 10 = MEM/WB result.
- Forwarding priority: the youngest match wins. An EX-entry match gives 01 and a MEM-entry match gives 10. A WB match gives 00, because the register file is write-before-read.
- stall (forwarding build): asserted when id_valid=1 and an rs or rt match hits the EX entry with is_load=1. This is the load-use case and costs exactly one cycle.
- Advance when hold=0:
  - WB<=MEM.
  - MEM<=EX.
  - EX<=ID entry, unless stall=1 or flush=1, in which case EX<=bubble (valid=0).
  - ex_fwd_rs/ex_fwd_rt are loaded with the selects computed for the ID instruction. They are loaded with 00 on a bubble.
- hold=1: all entries and outputs keep their values, and stall is still driven combinationally. hold takes priority over flush, so a held flush has no effect until hold drops.
- flush and stall together: EX gets a bubble either way and MEM/WB advance.
- Latency:
  - The selects become visible on the outputs one cycle after the ID instruction is accepted, i.e. during its EX cycle.
  - stall has zero latency.
- Reset (asynchronous):
  - All entries go to valid=0.
  - ex_fwd_rs=ex_fwd_rt=00.
  - stall evaluates to 0 because no entry is live.
- Reset mid-stall discards all pending writes. The stalled instruction re-issues with no hazard.
- Writes to register 0 never match and never stall.
- rs==rt is resolved independently and identically.

Optional Feature:
- Macro: SCOREBOARD_FORWARD_EN.
- Defined: forwarding as described above, with a load-use stall only.
- Undefined:
  - ex_fwd_rs/ex_fwd_rt are tied to 00.
  - stall is asserted on any match against a live EX or MEM entry, regardless of is_load.
  - A WB match still does not stall, because of the write-through register file.
  - Dependent back-to-back ALU ops therefore cost 2 stall cycles, and load-use costs 2.

Decomposition:
- Shared package holds:
  - FWD_REGFILE=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - The typedef sb_entry_t {valid, reg[REG_AW-1:0], is_load}.
  - REG_AW.
- One sub-module, sb_match: combinational. It takes one read (flag, index) plus the three entries and returns hit_ex, hit_ex_load, hit_mem and the priority-encoded select. It is instantiated twice, once for rs and once for rt.

Test Plan:
1. ADD $3 then ADD $4,$3,$3, back to back (FORWARD_EN) -> stall=0. In the second instruction's EX cycle, ex_fwd_rs=01 and ex_fwd_rt=01.
2. LW $5 then SUB $6,$5,$1 -> stall=1 for exactly one cycle. EX shows a bubble, then the SUB enters EX with ex_fwd_rs=10 and ex_fwd_rt=00.
3. ADDI $0,... then OR $7,$0,$0 -> stall=0 and both selects=00.
4. ADD $8, then an unrelated instruction, then SW $8 (rt read) -> ex_fwd_rt=10. A third-instruction dependency (WB match) gives 00.
5. A LW $9 load-use stall with hold=1 for 3 cycles -> stall stays 1, entries stay frozen and outputs are unchanged. It resolves normally after hold drops. flush during stall -> EX bubble, selects=00.
6. Macro undefined: ADD $3 then ADD $4,$3,$0 -> stall for 2 cycles, then selects=00. Assert rst mid-stall -> stall=0 immediately and selects=00.

Source files
------------

// File: rtl/reg_write_scoreboard_pkg.sv
// Shared types and constants for the register-write scoreboard.
// Forwarding is enabled by defining SCOREBOARD_FORWARD_EN.
package reg_write_scoreboard_pkg;

   localparam int REG_AW = 5;
   localparam int FWD_W  = 2;

   localparam logic [FWD_W-1:0] FWD_REGFILE = 2'b00;
   localparam logic [FWD_W-1:0] FWD_EXMEM   = 2'b01;
   localparam logic [FWD_W-1:0] FWD_MEMWB   = 2'b10;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              is_load;
   } sb_entry_t;

   // valid already folds in wr_en; r0 is never a real destination
   function automatic logic entry_live(sb_entry_t e);
      return e.valid && (e.rd != '0);
   endfunction

endpackage

// File: rtl/reg_write_scoreboard_sb_match.sv
// Compares one ID read port against the EX/MEM/WB pending writes.
// Youngest match wins; a WB match reads the write-through regfile.
module sb_match
   import reg_write_scoreboard_pkg::*;
(
   input  logic              rd_en,
   input  logic [REG_AW-1:0] rd_idx,
   input  sb_entry_t         ex_e,
   input  sb_entry_t         mem_e,
   input  sb_entry_t         wb_e,
   output logic              hit_ex,
   output logic              hit_ex_load,
   output logic              hit_mem,
   output logic [FWD_W-1:0]  sel
);

   logic req;
   logic hit_wb;

   assign req         = rd_en && (rd_idx != '0);
   assign hit_ex      = req && entry_live(ex_e) && (ex_e.rd == rd_idx);
   assign hit_ex_load = hit_ex && ex_e.is_load;
   assign hit_mem     = req && entry_live(mem_e) && (mem_e.rd == rd_idx);
   assign hit_wb      = req && entry_live(wb_e) && (wb_e.rd == rd_idx);

   always_comb begin
      sel = FWD_REGFILE;
      priority case (1'b1)
         hit_ex:  sel = FWD_EXMEM;
         hit_mem: sel = FWD_MEMWB;
         hit_wb:  sel = FWD_REGFILE;
         default: sel = FWD_REGFILE;
      endcase
   end

endmodule

// File: rtl/reg_write_scoreboard.sv
// Tracks in-flight GPR writes in EX/MEM/WB; drives stall and EX fwd selects.
// SCOREBOARD_FORWARD_EN: forward with load-use stall; else stall on EX/MEM hit.
module reg_write_scoreboard
   import reg_write_scoreboard_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              hold,
   input  logic              flush,
   input  logic              id_valid,
   input  logic              id_read_rs,
   input  logic              id_read_rt,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_wr_en,
   input  logic [REG_AW-1:0] id_wr_reg,
   input  logic              id_is_load,
   output logic              stall,
   output logic [FWD_W-1:0]  ex_fwd_rs,
   output logic [FWD_W-1:0]  ex_fwd_rt
);

   sb_entry_t ex_q, ex_d;
   sb_entry_t mem_q, mem_d;
   sb_entry_t wb_q, wb_d;
   logic [FWD_W-1:0] fwd_rs_q, fwd_rs_d;
   logic [FWD_W-1:0] fwd_rt_q, fwd_rt_d;

   logic rs_hit_ex, rs_hit_ex_load, rs_hit_mem;
   logic rt_hit_ex, rt_hit_ex_load, rt_hit_mem;
   logic [FWD_W-1:0] rs_sel, rt_sel;
   logic bubble;
   sb_entry_t id_e;

   sb_match u_match_rs (
      .rd_en       (id_read_rs),
      .rd_idx      (id_rs),
      .ex_e        (ex_q),
      .mem_e       (mem_q),
      .wb_e        (wb_q),
      .hit_ex      (rs_hit_ex),
      .hit_ex_load (rs_hit_ex_load),
      .hit_mem     (rs_hit_mem),
      .sel         (rs_sel)
   );

   sb_match u_match_rt (
      .rd_en       (id_read_rt),
      .rd_idx      (id_rt),
      .ex_e        (ex_q),
      .mem_e       (mem_q),
      .wb_e        (wb_q),
      .hit_ex      (rt_hit_ex),
      .hit_ex_load (rt_hit_ex_load),
      .hit_mem     (rt_hit_mem),
      .sel         (rt_sel)
   );

`ifdef SCOREBOARD_FORWARD_EN
   logic unused_hits;
   assign unused_hits = rs_hit_ex ^ rs_hit_mem ^ rt_hit_ex ^ rt_hit_mem;
   assign stall = id_valid && (rs_hit_ex_load || rt_hit_ex_load);
`else
   logic unused_fwd;
   assign unused_fwd = ^{rs_sel, rt_sel, rs_hit_ex_load, rt_hit_ex_load};
   // no bypass paths: wait until the producer reaches WB
   assign stall = id_valid &&
                  (rs_hit_ex || rs_hit_mem || rt_hit_ex || rt_hit_mem);
`endif

   always_comb begin
      ex_d     = ex_q;
      mem_d    = mem_q;
      wb_d     = wb_q;
      fwd_rs_d = fwd_rs_q;
      fwd_rt_d = fwd_rt_q;
      bubble   = stall || flush || !id_valid;
      id_e.valid   = id_valid && id_wr_en;
      id_e.rd      = id_wr_reg;
      id_e.is_load = id_is_load;
      if (!hold) begin
         wb_d  = mem_q;
         mem_d = ex_q;
         ex_d  = bubble ? '0 : id_e;
`ifdef SCOREBOARD_FORWARD_EN
         fwd_rs_d = bubble ? FWD_REGFILE : rs_sel;
         fwd_rt_d = bubble ? FWD_REGFILE : rt_sel;
`else
         fwd_rs_d = FWD_REGFILE;
         fwd_rt_d = FWD_REGFILE;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q     <= '0;
         mem_q    <= '0;
         wb_q     <= '0;
         fwd_rs_q <= FWD_REGFILE;
         fwd_rt_q <= FWD_REGFILE;
      end else begin
         ex_q     <= ex_d;
         mem_q    <= mem_d;
         wb_q     <= wb_d;
         fwd_rs_q <= fwd_rs_d;
         fwd_rt_q <= fwd_rt_d;
      end
   end

   assign ex_fwd_rs = fwd_rs_q;
   assign ex_fwd_rt = fwd_rt_q;

endmodule
